// File: rtl/fft_twiddle_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fft_twiddle_sequencer_pkg
// Shared constants, types and the twiddle-index helper for the FFT twiddle
// sequencer. The geometry is an 8-point radix-2 DIT FFT, so there are three
// stages of four butterflies, and each CWT scale owns four consecutive words
// in the twiddle ROM pair.
// ---------------------------------------------------------------------------
package fft_twiddle_sequencer_pkg;

  localparam int N_POINTS     = 8;
  localparam int STAGES       = $clog2(N_POINTS);
  localparam int TW_PER_SCALE = N_POINTS / 2;
  localparam int NUM_SCALES   = 7;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 16;
  localparam int FIFO_DEPTH   = 4;

  localparam int STAGE_W = $clog2(STAGES);
  localparam int BFLY_W  = $clog2(TW_PER_SCALE);
  localparam int SCALE_W = 3;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // Position of one twiddle in the stage-major / butterfly-minor walk
  typedef struct packed {
    logic [STAGE_W-1:0] stage;
    logic [BFLY_W-1:0]  bfly;
  } tw_tag_t;

  // One buffered twiddle: its position plus both ROM components
  typedef struct packed {
    tw_tag_t           tag;
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } tw_entry_t;

  localparam int ENTRY_W = $bits(tw_entry_t);

  // Twiddle index within a scale: k = (b & ((1<<s)-1)) << (STAGES-1-s).
  // The masked value is below 2^s, so the shift never leaves BFLY_W bits.
  function automatic logic [BFLY_W-1:0] tw_index(input logic [STAGE_W-1:0] s,
                                                 input logic [BFLY_W-1:0]  b);
    logic [BFLY_W-1:0]  mask;
    logic [STAGE_W-1:0] sh;
    mask = '0;
    for (int i = 0; i < BFLY_W; i++) begin
      mask[i] = (i < int'(s)) ? 1'b1 : 1'b0;
    end
    sh = STAGE_W'(STAGES - 1) - s;
    return (b & mask) << sh;
  endfunction

  // Full ROM address: scale base plus twiddle index
  function automatic logic [ADDR_W-1:0] tw_addr(input logic [SCALE_W-1:0] scale,
                                                input logic [STAGE_W-1:0] s,
                                                input logic [BFLY_W-1:0]  b);
    return (ADDR_W'(scale) * ADDR_W'(TW_PER_SCALE)) + ADDR_W'(tw_index(s, b));
  endfunction

endpackage

// File: rtl/fft_twiddle_sequencer_fifo.sv
// ---------------------------------------------------------------------------
// tw_sync_fifo
// Show-ahead synchronous FIFO: rdata_o always presents the head entry while
// valid_o is high. A push and a pop in the same cycle leave the count as is.
// Storage is cleared by reset so the head reads as zero when empty after reset.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   push_i   in   write wdata_i (ignored when full and not popping)
//   wdata_i  in   WIDTH  entry to write
//   pop_i    in   drop the head entry (ignored when empty)
//   rdata_o  out  WIDTH  head entry
//   valid_o  out  FIFO non-empty
//   count_o  out  CNT_W  number of stored entries
// ---------------------------------------------------------------------------
module tw_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against the current occupancy and compute next pointers
  always_comb begin
    do_pop_s  = pop_i && (count_q != CNT_W'(0));
    do_push_s = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != CNT_W'(0));
  assign count_o = count_q;

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// ---------------------------------------------------------------------------
// fft_twiddle_sequencer
// Reads the twiddles of one CWT scale from the real/imaginary ROM pair in
// FFT stage/butterfly order and hands them to the butterfly datapath over a
// valid/ready handshake. ROM reads are only issued while the output FIFO is
// guaranteed room for every read in flight, so backpressure never loses or
// re-reads a word.
//
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   start_i        in   request one scale (honoured in IDLE only)
//   scale_i        in   3       scale index, sampled with start_i
//   busy_o         out  sequence in progress
//   done_o         out  pulse when the last twiddle has been accepted
//   err_o          out  pulse when start_i names a scale that does not exist
//   rom_addr_o     out  ADDR_W  registered address to both ROMs
//   rom_re_data_i  in   DATA_W  real ROM data, one cycle after rom_addr_o
//   rom_im_data_i  in   DATA_W  imaginary ROM data, same timing
//   tw_valid_o     out  twiddle available
//   tw_ready_i     in   butterfly accepts the twiddle
//   tw_re_o        out  DATA_W  real component
//   tw_im_o        out  DATA_W  imaginary component
//   tw_stage_o     out  2       stage of the twiddle
//   tw_bfly_o      out  2       butterfly index within the stage
// ---------------------------------------------------------------------------
module fft_twiddle_sequencer
  import fft_twiddle_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [SCALE_W-1:0]  scale_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   rom_addr_o,
  input  logic [DATA_W-1:0]   rom_re_data_i,
  input  logic [DATA_W-1:0]   rom_im_data_i,
  output logic                tw_valid_o,
  input  logic                tw_ready_i,
  output logic [DATA_W-1:0]   tw_re_o,
  output logic [DATA_W-1:0]   tw_im_o,
  output logic [STAGE_W-1:0]  tw_stage_o,
  output logic [BFLY_W-1:0]   tw_bfly_o
);

  localparam int OCC_W = CNT_W + 1;

  seq_state_e         state_q, state_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic [STAGE_W-1:0] s_q, s_d;
  logic [BFLY_W-1:0]  b_q, b_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Tag pipe: stage 0 is aligned with rom_addr, stage 1 with ROM data
  logic               tag0_v_q, tag1_v_q;
  tw_tag_t            tag0_q, tag1_q;
  tw_tag_t            issue_tag_s;
  logic               issue_s;

  logic [1:0]         inflight_s;
  logic               issue_ok_s;
  logic               pop_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_valid_s;
  tw_entry_t          push_entry_s;
  tw_entry_t          head_s;

  // Reads in flight plus buffered entries must never exceed the FIFO depth
  always_comb begin
    inflight_s = {1'b0, tag0_v_q} + {1'b0, tag1_v_q};
    issue_ok_s = ({1'b0, fifo_count_s} + OCC_W'(inflight_s)) < OCC_W'(FIFO_DEPTH);
    pop_s      = fifo_valid_s && tw_ready_i;
  end

  // Sequencer FSM: next state, counters, ROM address and status pulses
  always_comb begin
    state_d           = state_q;
    scale_d           = scale_q;
    s_d               = s_q;
    b_d               = b_q;
    rom_addr_d        = rom_addr_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    err_d             = 1'b0;
    issue_s           = 1'b0;
    issue_tag_s.stage = s_q;
    issue_tag_s.bfly  = b_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (scale_i < SCALE_W'(NUM_SCALES)) begin
            scale_d = scale_i;
            s_d     = '0;
            b_d     = '0;
            busy_d  = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_ok_s) begin
          issue_s    = 1'b1;
          rom_addr_d = tw_addr(scale_q, s_q, b_q);
          if (b_q == BFLY_W'(TW_PER_SCALE - 1)) begin
            b_d = '0;
            if (s_q == STAGE_W'(STAGES - 1)) begin
              s_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              s_d = s_q + STAGE_W'(1);
            end
          end else begin
            b_d = b_q + BFLY_W'(1);
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        // Finish on the edge that takes the final entry, so done lines up
        // with the acceptance of the last twiddle.
        if ((inflight_s == 2'd0) &&
            ((fifo_count_s == CNT_W'(0)) ||
             ((fifo_count_s == CNT_W'(1)) && pop_s))) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and registered status/address outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      scale_q    <= '0;
      s_q        <= '0;
      b_q        <= '0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scale_q    <= scale_d;
      s_q        <= s_d;
      b_q        <= b_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Tag pipe carrying stage/butterfly alongside the ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag0_v_q <= 1'b0;
      tag1_v_q <= 1'b0;
      tag0_q   <= '0;
      tag1_q   <= '0;
    end else begin
      tag0_v_q <= issue_s;
      tag0_q   <= issue_tag_s;
      tag1_v_q <= tag0_v_q;
      tag1_q   <= tag0_q;
    end
  end

  // Assemble the FIFO entry from the tag and the ROM data that arrive together
  always_comb begin
    push_entry_s.tag = tag1_q;
    push_entry_s.re  = rom_re_data_i;
    push_entry_s.im  = rom_im_data_i;
  end

  tw_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tag1_v_q),
    .wdata_i (push_entry_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .valid_o (fifo_valid_s),
    .count_o (fifo_count_s)
  );

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rom_addr_o = rom_addr_q;
  assign tw_valid_o = fifo_valid_s;
  assign tw_re_o    = head_s.re;
  assign tw_im_o    = head_s.im;
  assign tw_stage_o = head_s.tag.stage;
  assign tw_bfly_o  = head_s.tag.bfly;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_twiddle_sequencer
// Directed bench: a registered ROM model, a monitor that records every
// accepted twiddle and checks hold-while-stalled, and directed scenarios
// compared against hand-computed address offsets and ROM contents.
// Inputs change 2 time units after the rising edge; outputs are read at
// that same point or at the falling edge.
// ---------------------------------------------------------------------------
module tb_fft_twiddle_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  scale;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  rom_addr;
  logic [15:0] rom_re;
  logic [15:0] rom_im;
  logic        tw_valid;
  logic        tw_ready;
  logic [15:0] tw_re;
  logic [15:0] tw_im;
  logic [1:0]  tw_stage;
  logic [1:0]  tw_bfly;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [35:0] acc_q [$];
  int          off_tbl [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  logic        stall_prev = 1'b0;
  logic [36:0] prev_tw    = '0;

  fft_twiddle_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .scale_i       (scale),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .rom_addr_o    (rom_addr),
    .rom_re_data_i (rom_re),
    .rom_im_data_i (rom_im),
    .tw_valid_o    (tw_valid),
    .tw_ready_i    (tw_ready),
    .tw_re_o       (tw_re),
    .tw_im_o       (tw_im),
    .tw_stage_o    (tw_stage),
    .tw_bfly_o     (tw_bfly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_re_f(input logic [4:0] a);
    return 16'h1000 + ({11'd0, a} * 16'd257);
  endfunction

  function automatic logic [15:0] rom_im_f(input logic [4:0] a);
    return 16'hF00F ^ ({11'd0, a} * 16'd33);
  endfunction

  // Registered-read ROM pair
  always @(posedge clk) begin
    rom_re <= rom_re_f(rom_addr);
    rom_im <= rom_im_f(rom_addr);
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: record accepted twiddles, and require tw_* to hold while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check_eq("stall_hold", {tw_valid, tw_stage, tw_bfly, tw_re, tw_im}, prev_tw);
      if (tw_valid && tw_ready)
        acc_q.push_back({tw_stage, tw_bfly, tw_re, tw_im});
      stall_prev = tw_valid && !tw_ready;
      prev_tw    = {tw_valid, tw_stage, tw_bfly, tw_re, tw_im};
    end
  end

  task automatic do_start(input logic [2:0] sc);
    @(posedge clk); #2;
    start = 1'b1;
    scale = sc;
    @(posedge clk); #2;   // this edge is E0
    start = 1'b0;
  endtask

  task automatic check_seq(input int sc);
    logic [4:0]  a;
    logic [35:0] exp;
    check_eq("tw_count", 64'(acc_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < acc_q.size(); i++) begin
      a   = 5'(sc * 4 + off_tbl[i]);
      exp = {2'(i / 4), 2'(i % 4), rom_re_f(a), rom_im_f(a)};
      check_eq($sformatf("tw[%0d] sc%0d", i, sc), 64'(acc_q[i]), 64'(exp));
    end
  endtask

  // Full sequence with tw_ready high; optionally re-pulse start at E5
  task automatic run_full(input int sc, input bit restart);
    int n_done;
    n_done = 0;
    acc_q.delete();
    tw_ready = 1'b1;
    do_start(3'(sc));
    check_eq("busy_after_start", 64'(busy), 64'd1);
    for (int e = 1; e <= 18; e++) begin
      @(posedge clk); #2;
      if (e <= 12)
        check_eq($sformatf("rom_addr E%0d sc%0d", e, sc), 64'(rom_addr), 64'(sc * 4 + off_tbl[e - 1]));
      if (e == 2) check_eq("valid_E2", 64'(tw_valid), 64'd0);
      if (e == 3) check_eq("valid_E3", 64'(tw_valid), 64'd1);
      if (e == 14) check_eq("done_busy_E14", 64'({done, busy}), 64'b01);
      if (e == 15) check_eq("done_busy_E15", 64'({done, busy}), 64'b10);
      if (restart && e == 4) begin
        start = 1'b1;
        scale = 3'd1;
      end
      if (restart && e == 5) start = 1'b0;
      if (done) n_done++;
    end
    check_eq("done_pulses", 64'(n_done), 64'd1);
    check_seq(sc);
  endtask

  initial begin
    logic [4:0] saved_addr;
    bit         got_done;
    rst_n    = 1'b0;
    start    = 1'b0;
    scale    = 3'd0;
    tw_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("reset_ctl", 64'({busy, done, err, rom_addr}), 64'd0);
    check_eq("reset_tw", 64'({tw_valid, tw_stage, tw_bfly, tw_re, tw_im}), 64'd0);
    rst_n = 1'b1;

    // Scale 0 and scale 5 with tw_ready held high
    run_full(0, 1'b0);
    run_full(5, 1'b0);

    // Random backpressure, about 30% ready
    acc_q.delete();
    tw_ready = 1'b0;
    do_start(3'd3);
    got_done = 1'b0;
    for (int c = 0; c < 600 && !got_done; c++) begin
      @(posedge clk); #2;
      if (done) got_done = 1'b1;
      else tw_ready = ($urandom_range(0, 9) < 3);
    end
    check_eq("rand_done", 64'(got_done), 64'd1);
    tw_ready = 1'b1;
    check_seq(3);

    // Out-of-range scale is refused
    @(posedge clk); #2;
    saved_addr = rom_addr;
    do_start(3'd7);
    check_eq("err_pulse", 64'({err, busy}), 64'b10);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      check_eq("err_after", 64'({err, busy, tw_valid, rom_addr}), 64'({3'b000, saved_addr}));
    end

    // Second start while busy is ignored
    run_full(2, 1'b1);

    // Reset in mid-sequence with six twiddles delivered
    acc_q.delete();
    tw_ready = 1'b1;
    do_start(3'd4);
    got_done = 1'b0;
    for (int c = 0; c < 50 && !got_done; c++) begin
      @(posedge clk); #2;
      if (acc_q.size() >= 6) begin
        tw_ready = 1'b0;
        got_done = 1'b1;
      end
    end
    check_eq("six_delivered", 64'(acc_q.size()), 64'd6);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ctl", 64'({busy, done, err, rom_addr}), 64'd0);
    check_eq("midrst_tw", 64'({tw_valid, tw_stage, tw_bfly, tw_re, tw_im}), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #2;
      check_eq("midrst_no_done", 64'({done, busy, tw_valid}), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
    check_eq("post_rst_idle", 64'({done, busy, tw_valid}), 64'd0);
    run_full(6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
